// File: rtl/wb_tlc_pkg.sv
// Shared wb_tlc definitions: credit counter width, credit-return FSM
// encoding and a helper that sizes down-counters from their load value.
package wb_tlc_pkg;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACC   = 2'd1,
    ST_ISSUE = 2'd2,
    ST_GAP   = 2'd3
  } cr_state_e;

  // Bits needed for a down-counter that is loaded with (maxval - 1).
  function automatic int cnt_w_for(input int maxval);
    return (maxval < 2) ? 1 : $clog2(maxval);
  endfunction

endpackage

// File: rtl/wb_tlc_cr_acc.sv
// Credit-return accumulator. Collects single-cycle credit pulses from
// wb_tlc_cr and hands them back to the PCIe core in batches: on reaching a
// threshold, when a timeout since the first pending credit expires, or
// while flush is high. Consecutive returns are separated by a quiet gap.
module wb_tlc_cr_acc
  import wb_tlc_pkg::*;
#(
  parameter int THRESH  = 8,
  parameter int TIMEOUT = 64,
  parameter int GAP     = 4
) (
  input  logic             clk_125,
  input  logic             rstn,
  input  logic             cr_125,
  input  logic             flush,
  output logic             cr_ret,
  output logic [CNT_W-1:0] cr_num,
  output logic [CNT_W-1:0] cr_pend,
  output logic             cr_ovf
);

  localparam int TMR_W   = cnt_w_for(TIMEOUT);
  localparam int GAP_W   = cnt_w_for(GAP);
  // Thresholds outside 1..255 are clamped to the nearest usable value.
  localparam int THR_EFF = (THRESH > 255) ? 255 : ((THRESH < 1) ? 1 : THRESH);

  localparam logic [CNT_W-1:0] THR_V    = CNT_W'(THR_EFF);
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP - 1);

  if (TIMEOUT < 1 || GAP < 1) begin : g_bad_param
    $error("wb_tlc_cr_acc: TIMEOUT and GAP must both be at least 1");
  end

  cr_state_e        state;
  logic [CNT_W-1:0] pend;
  logic [TMR_W-1:0] timer;
  logic [GAP_W-1:0] gap_cnt;

  logic [CNT_W-1:0] pend_inc;
  logic             sat_hit;
  logic             tmr_exp;
  logic             go_issue;

  // Next pending count with saturation, and the reasons to issue a return.
  always_comb begin
    sat_hit  = cr_125 && (pend == '1);
    pend_inc = (cr_125 && !sat_hit) ? pend + 1'b1 : pend;
    // The window closes on the edge where the countdown reaches zero, so a
    // lone credit is returned TIMEOUT cycles after it arrived.
    tmr_exp  = (timer <= TMR_W'(1));
    go_issue = (pend >= THR_V) || tmr_exp || flush;
  end

  // Return FSM, pending counter, window timer, gap counter and outputs.
  always_ff @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      pend    <= '0;
      timer   <= '0;
      gap_cnt <= '0;
      cr_ret  <= 1'b0;
      cr_num  <= '0;
      cr_ovf  <= 1'b0;
    end else begin
      cr_ret <= 1'b0;
      cr_num <= '0;
      pend   <= pend_inc;
      if (sat_hit) begin
        cr_ovf <= 1'b1;
      end
      unique case (state)
        ST_IDLE: begin
          if (pend_inc != '0) begin
            state <= ST_ACC;
            timer <= TMR_LOAD;
          end
        end
        ST_ACC: begin
          if (go_issue) begin
            // The batch is the count seen while deciding; a pulse arriving
            // on this same edge starts the next batch instead of being lost.
            state  <= ST_ISSUE;
            cr_ret <= 1'b1;
            cr_num <= pend;
            pend   <= {{(CNT_W-1){1'b0}}, cr_125};
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_ISSUE: begin
          state   <= ST_GAP;
          gap_cnt <= GAP_LOAD;
        end
        ST_GAP: begin
          if (gap_cnt == '0) begin
            if (pend_inc != '0) begin
              state <= ST_ACC;
              timer <= TMR_LOAD;
            end else begin
              state <= ST_IDLE;
            end
          end else begin
            gap_cnt <= gap_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign cr_pend = pend;

endmodule

// File: tb/tb_wb_tlc_cr_acc.sv
// Bench for wb_tlc_cr_acc: a default-parameter instance and a saturation
// instance (threshold clamped to 255, long timeout), each tracked by a
// cycle-numbered reference model built on return windows and deadlines.
module tb_wb_tlc_cr_acc;

  localparam int THA = 8;
  localparam int TOA = 64;
  localparam int GPA = 4;
  localparam int THB = 300;
  localparam int TOB = 1000;
  localparam int GPB = 4;
  localparam int THA_EFF = (THA > 255) ? 255 : ((THA < 1) ? 1 : THA);
  localparam int THB_EFF = (THB > 255) ? 255 : ((THB < 1) ? 1 : THB);

  logic       clk_125 = 1'b0;
  logic       rstn = 1'b0;
  logic       cr_a = 1'b0, fl_a = 1'b0, cr_b = 1'b0, fl_b = 1'b0;
  logic       cr_ret_a, cr_ret_b, cr_ovf_a, cr_ovf_b;
  logic [7:0] cr_num_a, cr_num_b, cr_pend_a, cr_pend_b;
  logic [17:0] obs_a, obs_b;

  int nchk = 0;
  int nfail = 0;
  int cyc = 0;

  always #4 clk_125 = ~clk_125;

  wb_tlc_cr_acc #(.THRESH(THA), .TIMEOUT(TOA), .GAP(GPA)) dut_a (
    .clk_125(clk_125), .rstn(rstn), .cr_125(cr_a), .flush(fl_a),
    .cr_ret(cr_ret_a), .cr_num(cr_num_a), .cr_pend(cr_pend_a), .cr_ovf(cr_ovf_a));

  wb_tlc_cr_acc #(.THRESH(THB), .TIMEOUT(TOB), .GAP(GPB)) dut_b (
    .clk_125(clk_125), .rstn(rstn), .cr_125(cr_b), .flush(fl_b),
    .cr_ret(cr_ret_b), .cr_num(cr_num_b), .cr_pend(cr_pend_b), .cr_ovf(cr_ovf_b));

  assign obs_a = {cr_ret_a, cr_num_a, cr_pend_a, cr_ovf_a};
  assign obs_b = {cr_ret_b, cr_num_b, cr_pend_b, cr_ovf_b};

  // Reference model. win = first cycle a return may be decided (-1 if no
  // window is open); reopen = cycle at which the post-return quiet period
  // ends; idle = nothing pending and no window or quiet period active.
  typedef struct {
    int pend;
    bit ovf;
    int win;
    int reopen;
    bit idle;
    bit ret;
    int num;
  } mdl_t;

  mdl_t ma, mb;

  function automatic void mreset(output mdl_t s);
    s.pend = 0; s.ovf = 0; s.win = -1; s.reopen = -1; s.idle = 1;
    s.ret = 0; s.num = 0;
  endfunction

  function automatic void mstep(inout mdl_t s, input bit cr, input bit fl,
                                input int n, input int th, input int to, input int gp);
    int pinc;
    bit dec;
    pinc = (s.pend + int'(cr) > 255) ? 255 : s.pend + int'(cr);
    if (s.pend == 255 && cr) s.ovf = 1;
    dec = (s.win >= 0) && (n >= s.win) &&
          (s.pend >= th || fl || n >= s.win + ((to > 2) ? to - 2 : 0));
    s.ret = 0;
    s.num = 0;
    if (dec) begin
      s.ret = 1; s.num = s.pend; s.pend = int'(cr);
      s.win = -1; s.reopen = n + 1 + gp;
    end else begin
      s.pend = pinc;
      if (s.win < 0 && (s.idle || n == s.reopen)) begin
        if (pinc != 0) begin
          s.win = n + 1; s.idle = 0;
        end else begin
          s.idle = 1;
        end
      end
    end
  endfunction

  function automatic logic [17:0] mexp(input mdl_t s);
    return {s.ret, 8'(s.num), 8'(s.pend), s.ovf};
  endfunction

  always @(posedge clk_125 or negedge rstn) begin
    if (!rstn) begin
      mreset(ma);
      mreset(mb);
    end else begin
      mstep(ma, cr_a, fl_a, cyc, THA_EFF, TOA, GPA);
      mstep(mb, cr_b, fl_b, cyc, THB_EFF, TOB, GPB);
    end
    cyc++;
  end

  task automatic apply_reset();
    @(negedge clk_125);
    cr_a = 0; fl_a = 0; cr_b = 0; fl_b = 0; rstn = 0;
    @(negedge clk_125);
    rstn = 1;
  endtask

  task automatic test_reset();
    rstn = 0; cr_a = 0; fl_a = 0; cr_b = 0; fl_b = 0;
    repeat (2) @(negedge clk_125);
    nchk++;
    if (obs_a !== 18'h0) begin nfail++; $display("FAIL reset_a got %h want 0", obs_a); end
    nchk++;
    if (obs_b !== 18'h0) begin nfail++; $display("FAIL reset_b got %h want 0", obs_b); end
    rstn = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL reset_idle i=%0d got %h want %h", i, obs_a, mexp(ma)); end
    end
  endtask

  task automatic test_threshold();
    int nret, rnum, rat;
    apply_reset();
    nret = 0; rnum = -1; rat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL threshold i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (cr_ret_a) begin nret++; rnum = int'(cr_num_a); rat = i; end
      cr_a = (i < 8);
    end
    cr_a = 0;
    nchk++;
    if (nret !== 1 || rnum !== 8 || rat !== 9) begin
      nfail++; $display("FAIL threshold_ret count/num/at=%0d/%0d/%0d want 1/8/9", nret, rnum, rat);
    end
  endtask

  task automatic test_timeout();
    int nret, rnum, rat;
    apply_reset();
    nret = 0; rnum = -1; rat = -1;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL timeout i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (cr_ret_a) begin nret++; rnum = int'(cr_num_a); rat = i; end
      cr_a = (i < 3);
    end
    cr_a = 0;
    nchk++;
    if (nret !== 1 || rnum !== 3 || rat !== 64) begin
      nfail++; $display("FAIL timeout_ret count/num/at=%0d/%0d/%0d want 1/3/64", nret, rnum, rat);
    end
  endtask

  task automatic test_simultaneous();
    int nums[$];
    int rat;
    bit fired;
    apply_reset();
    rat = -1; fired = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL simult i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (rat >= 0 && i == rat + 1) begin
        nchk++;
        if (cr_pend_a !== 8'd1) begin nfail++; $display("FAIL simult_pend got %0d want 1", cr_pend_a); end
      end
      if (cr_ret_a) begin
        nums.push_back(int'(cr_num_a));
        if (rat < 0) rat = i;
      end
      cr_a = (i < 8) || (cr_ret_a && !fired);
      if (cr_ret_a) fired = 1;
    end
    cr_a = 0;
    nchk++;
    if (nums.size() !== 2) begin
      nfail++; $display("FAIL simult_count got %0d want 2", nums.size());
    end else begin
      nchk++;
      if (nums[0] !== 8 || nums[1] !== 1) begin
        nfail++; $display("FAIL simult_nums got %0d,%0d want 8,1", nums[0], nums[1]);
      end
    end
  endtask

  task automatic test_spacing();
    int nums[$];
    int last, mingap, total;
    apply_reset();
    last = -1000; mingap = 1000; total = 0;
    for (int i = 0; i < 110; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL spacing i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (cr_ret_a) begin
        nums.push_back(int'(cr_num_a));
        total += int'(cr_num_a);
        if (i - last < mingap) mingap = i - last;
        last = i;
      end
      cr_a = (i < 20);
    end
    cr_a = 0;
    nchk++;
    if (nums.size() !== 3) begin
      nfail++; $display("FAIL spacing_count got %0d want 3", nums.size());
    end else begin
      nchk++;
      if (nums[0] !== 8 || nums[1] !== 8 || nums[2] !== 4) begin
        nfail++; $display("FAIL spacing_nums got %0d,%0d,%0d want 8,8,4", nums[0], nums[1], nums[2]);
      end
    end
    nchk++;
    if (mingap < GPA + 1 || total !== 20) begin
      nfail++; $display("FAIL spacing_gap mingap=%0d total=%0d want >=%0d and 20", mingap, total, GPA + 1);
    end
  endtask

  task automatic test_flush();
    int early, total;
    apply_reset();
    early = 0; total = 0;
    fl_a = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL flush i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (cr_ret_a) begin
        total += int'(cr_num_a);
        if (i < 12) early++;
      end
      cr_a = (i == 12) || (i == 13) || (i == 20);
    end
    cr_a = 0; fl_a = 0;
    nchk++;
    if (early !== 0 || total !== 3) begin
      nfail++; $display("FAIL flush_ret empty_rets=%0d total=%0d want 0 and 3", early, total);
    end
  endtask

  task automatic test_random();
    int last, total_in, total_out;
    apply_reset();
    last = -1000; total_in = 0; total_out = 0;
    for (int i = 0; i < 600; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL random i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (cr_ret_a) begin
        total_out += int'(cr_num_a);
        nchk++;
        if (i - last < GPA + 1) begin nfail++; $display("FAIL random_gap i=%0d gap=%0d want >=%0d", i, i - last, GPA + 1); end
        last = i;
      end
      if (i < 500) begin
        cr_a = ($urandom_range(0, 99) < 45);
        fl_a = ($urandom_range(0, 99) < 8);
      end else begin
        cr_a = 0; fl_a = 0;
      end
      if (cr_a && i < 599) total_in++;
    end
    cr_a = 0; fl_a = 0;
    nchk++;
    if (total_out + int'(cr_pend_a) !== total_in) begin
      nfail++; $display("FAIL random_conserve returned+pending=%0d want %0d", total_out + int'(cr_pend_a), total_in);
    end
  endtask

  task automatic test_saturation();
    int rnum, rat;
    apply_reset();
    rnum = -1; rat = -1;
    for (int i = 0; i < 330; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_b !== mexp(mb)) begin nfail++; $display("FAIL sat i=%0d got %h want %h", i, obs_b, mexp(mb)); end
      if (i == 255) begin
        nchk++;
        if (cr_ovf_b !== 1'b0) begin nfail++; $display("FAIL sat_ovf_early got %0b want 0", cr_ovf_b); end
      end
      if (cr_ret_b && rat < 0) begin rnum = int'(cr_num_b); rat = i; end
      cr_b = (i < 300);
    end
    cr_b = 0;
    nchk++;
    if (rnum !== 255 || rat !== 256 || cr_ovf_b !== 1'b1) begin
      nfail++; $display("FAIL sat_ret num/at/ovf=%0d/%0d/%0b want 255/256/1", rnum, rat, cr_ovf_b);
    end
    apply_reset();
    @(negedge clk_125);
    nchk++;
    if (cr_ovf_b !== 1'b0) begin nfail++; $display("FAIL sat_ovf_clear got %0b want 0", cr_ovf_b); end
  endtask

  task automatic test_sat_exact();
    int rnum;
    apply_reset();
    rnum = -1;
    for (int i = 0; i < 270; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_b !== mexp(mb)) begin nfail++; $display("FAIL sat_exact i=%0d got %h want %h", i, obs_b, mexp(mb)); end
      if (cr_ret_b && rnum < 0) rnum = int'(cr_num_b);
      cr_b = (i < 255);
    end
    cr_b = 0;
    nchk++;
    if (rnum !== 255 || cr_ovf_b !== 1'b0) begin
      nfail++; $display("FAIL sat_exact_ret num/ovf=%0d/%0b want 255/0", rnum, cr_ovf_b);
    end
  endtask

  task automatic test_reset_mid();
    int nret;
    apply_reset();
    nret = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL rst_mid_pre i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      cr_a = (i < 5);
    end
    cr_a = 0;
    @(negedge clk_125);
    nchk++;
    if (cr_pend_a !== 8'd5) begin nfail++; $display("FAIL rst_mid_pend got %0d want 5", cr_pend_a); end
    #1;
    rstn = 0;
    #1;
    nchk++;
    if (obs_a !== 18'h0) begin nfail++; $display("FAIL rst_mid_async got %h want 0", obs_a); end
    @(negedge clk_125);
    rstn = 1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk_125);
      nchk++;
      if (obs_a !== mexp(ma)) begin nfail++; $display("FAIL rst_mid_post i=%0d got %h want %h", i, obs_a, mexp(ma)); end
      if (cr_ret_a) nret++;
    end
    nchk++;
    if (nret !== 0) begin nfail++; $display("FAIL rst_mid_noret got %0d returns want 0", nret); end
  endtask

  initial begin
    test_reset();
    test_threshold();
    test_timeout();
    test_simultaneous();
    test_spacing();
    test_flush();
    test_random();
    test_saturation();
    test_sat_exact();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/wb_tlc_cr_acc.md
WB_TLC_CR_ACC -- requirements
Module: wb_tlc_cr_acc

Interface
REQ-001 SHALL have parameter THRESH, default 8: pending-credit count that triggers an immediate return.
REQ-002 SHALL have parameter TIMEOUT, default 64: clk_125 cycles after the first pending credit before a forced return.
REQ-003 SHALL have parameter GAP, default 4: minimum idle cycles after each cr_ret pulse.
REQ-004 SHALL have port clk_125, input, 1: sole clock; all logic on its rising edge.
REQ-005 SHALL have port rstn, input, 1: asynchronous active-low reset.
REQ-006 SHALL have port cr_125, input, 1: single-cycle pulse, one credit consumed; already synchronous to clk_125.
REQ-007 SHALL have port flush, input, 1: level; while high, any pending credits return without waiting.
REQ-008 SHALL have port cr_ret, output, 1: single-cycle credit-return strobe to the PCIe core.
REQ-009 SHALL have port cr_num, output, 8: credits returned; valid only while cr_ret=1, else 0.
REQ-010 SHALL have port cr_pend, output, 8: current pending count.
REQ-011 SHALL have port cr_ovf, output, 1: sticky saturation error.

Function
REQ-012 Pending counter pend[7:0] SHALL increment by 1 on each cycle with cr_125=1.
- At 255 it SHALL hold at 255 and set cr_ovf.
REQ-013 FSM states SHALL be IDLE, ACC, ISSUE and GAP.
REQ-014 IDLE: when pend becomes non-zero, go to ACC and load the timer with TIMEOUT-1.
REQ-015 ACC: decrement the timer each cycle.
- Go to ISSUE when pend>=THRESH, or timer==0, or flush=1.
REQ-016 ISSUE (one cycle):
- cr_ret=1 and cr_num=pend (value registered at ISSUE entry).
- Next pend = (cr_125 ? 1 : 0), so a pulse arriving in the ISSUE cycle is kept, never lost or double-counted.
- Then go to GAP with the gap counter loaded to GAP-1.
REQ-017 GAP: count down; cr_125 keeps accumulating.
- At 0, go to ACC if pend!=0 (timer reloaded to TIMEOUT-1), else go to IDLE.
REQ-018 cr_ret SHALL never assert on two cycles closer than GAP+1 apart.
REQ-019 Latency from the cr_125 pulse that makes pend reach THRESH to cr_ret SHALL be 2 cycles: pend updates, FSM enters ISSUE, cr_ret registered out.
REQ-020 All outputs SHALL be registered (no combinational path from an input to an output).
REQ-021 flush=1 with pend==0 SHALL cause no cr_ret.
REQ-022 THRESH>255 or THRESH==0 SHALL be treated as 255 and 1 respectively.
- TIMEOUT and GAP SHALL each be >=1, checked by an elaboration-time assertion.
REQ-023 cr_ovf SHALL clear only on reset.

Reset
REQ-024 rstn=0 SHALL asynchronously force:
- FSM to IDLE;
- pend, timer and gap counter to 0;
- cr_ret=0, cr_num=0, cr_pend=0, cr_ovf=0.
REQ-025 Release SHALL take effect on the first clk_125 edge after rstn rises; no synchronizer inside the block.
REQ-026 Reset mid-ISSUE SHALL discard pending credits; the core re-initializes credits on link reset.

Structure
REQ-027 The FSM state encoding and the counter widths (CNT_W=8, timer width from TIMEOUT) SHALL live in the shared wb_tlc package.
REQ-028 The block SHALL be a single module with no sub-modules; the down-counter is inline.
REQ-029 The block SHALL be instantiated directly after wb_tlc_cr, with cr_125 connected unmodified.

Verification
REQ-030 Threshold:
- Stimulus: 8 back-to-back cr_125 pulses.
- Required: exactly one cr_ret, cr_num=8, 2 cycles after the 8th pulse.
REQ-031 Timeout:
- Stimulus: 3 pulses, then silence.
- Required: cr_ret with cr_num=3, 64 cycles after the first pulse.
REQ-032 Simultaneous event:
- Stimulus: a cr_125 pulse in the ISSUE cycle.
- Required: cr_num excludes it; cr_pend=1 in the next cycle; it is returned in a later cr_ret.
REQ-033 Spacing:
- Stimulus: 20 consecutive pulses.
- Required: returns 8, 8, 4 (after timeout) with each cr_ret gap >=5 cycles; total returned = 20.
REQ-034 Saturation:
- Stimulus: 300 pulses with flush=0 and THRESH=255.
- Required: a return of 255 and cr_ovf=1 only if a pulse arrived at pend=255; cr_ovf stays 1 until rstn.
REQ-035 Reset:
- Stimulus: rstn low during ACC with pend=5.
- Required: all outputs 0 immediately (asynchronous); no cr_ret after release without new pulses.
